h2f_vram_bridge: RTL and testbench

HPS-side end of the h2f VRAM interface; the PPU is the receiving end. It is an Avalon-MM slave in the fpgame_soc fabric that buffers CPU VRAM writes in a FIFO. It drains those writes onto the h2f_vram port only while the PPU is not busy. On a CPU "commit", it fences all buffered writes, pulses cpu_vram_wr_irq so the PPU swaps/copies VRAM, and then tracks the PPU's cpu_wr_busy acknowledge.

---
 rtl/h2f_vram_bridge_if.sv | 36 +++
 rtl/h2f_vram_bridge.sv | 159 +++++++++++++++
 tb/tb_h2f_vram_bridge.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/h2f_vram_bridge_if.sv
// Avalon-MM slave bus plus the h2f VRAM write port between the HPS bridge and the PPU.
// The bridge uses the slave modport; the CPU/PPU side (or a bench) uses master.
interface h2f_vram_bridge_if;
  localparam int unsigned AVS_AW = 14;
  localparam int unsigned DW     = 64;
  localparam int unsigned BEW    = 8;
  localparam int unsigned VAW    = 13;

  logic [AVS_AW-1:0] avs_address;
  logic              avs_write;
  logic [DW-1:0]     avs_writedata;
  logic [BEW-1:0]    avs_byteenable;
  logic              avs_read;
  logic [DW-1:0]     avs_readdata;
  logic              avs_readdatavalid;
  logic              avs_waitrequest;

  logic [VAW-1:0]    h2f_vram_wraddr;
  logic              h2f_vram_wren;
  logic [DW-1:0]     h2f_vram_wrdata;
  logic [BEW-1:0]    h2f_vram_byteena;
  logic              cpu_vram_wr_irq;
  logic              cpu_wr_busy;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_byteenable, avs_read, cpu_wr_busy,
    output avs_readdata, avs_readdatavalid, avs_waitrequest,
    output h2f_vram_wraddr, h2f_vram_wren, h2f_vram_wrdata, h2f_vram_byteena, cpu_vram_wr_irq
  );

  modport master (
    output avs_address, avs_write, avs_writedata, avs_byteenable, avs_read, cpu_wr_busy,
    input  avs_readdata, avs_readdatavalid, avs_waitrequest,
    input  h2f_vram_wraddr, h2f_vram_wren, h2f_vram_wrdata, h2f_vram_byteena, cpu_vram_wr_irq
  );
endinterface

// File: rtl/h2f_vram_bridge.sv
// HPS-side h2f VRAM bridge: buffers CPU VRAM writes, drains them to the PPU while it is
// idle, and on commit fences the buffer, pulses the PPU irq and waits for its busy ack.
module h2f_vram_bridge #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  h2f_vram_bridge_if.slave bus
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef struct packed {
    logic [12:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DRAIN, NOTIFY, WAIT_ACK} state_t;

  state_t          state;
  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   ack_cnt;
  logic            ack_seen;
  logic            timeout;

  logic            empty_c;
  logic            full_c;
  logic            is_csr_c;
  logic            wr_ok_c;
  logic            wr_acc_c;
  logic            push_c;
  logic            pop_c;
  logic            commit_c;
  logic            clr_to_c;
  logic            rd_c;
  logic [63:0]     csr_word_c;
  entry_t          head_c;

  always_comb begin
    empty_c    = (count == '0);
    full_c     = (count == CW'(FIFO_DEPTH));
    is_csr_c   = bus.avs_address[13];
    wr_ok_c    = (state == IDLE) && (is_csr_c || !full_c);
    wr_acc_c   = bus.avs_write && wr_ok_c;
    push_c     = wr_acc_c && !is_csr_c && (bus.avs_byteenable != '0);
    pop_c      = ((state == IDLE) || (state == DRAIN)) && !empty_c && !bus.cpu_wr_busy;
    commit_c   = wr_acc_c && is_csr_c && bus.avs_writedata[0];
    clr_to_c   = wr_acc_c && is_csr_c && bus.avs_writedata[1];
    rd_c       = bus.avs_read && !bus.avs_write;
    head_c     = mem[rd_ptr];
    csr_word_c = {48'b0, 8'(count), 5'b0, timeout, (state != IDLE), empty_c};
  end

  // Writes stall only while a commit is in flight or the buffer is full.
  assign bus.avs_waitrequest = bus.avs_write && !wr_ok_c;

  // Buffer storage carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{addr: bus.avs_address[12:0],
                       data: bus.avs_writedata,
                       be:   bus.avs_byteenable};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // h2f write port: popped head is presented for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.h2f_vram_wren    <= 1'b0;
      bus.h2f_vram_wraddr  <= '0;
      bus.h2f_vram_wrdata  <= '0;
      bus.h2f_vram_byteena <= '0;
    end else begin
      bus.h2f_vram_wren <= pop_c;
      if (pop_c) begin
        bus.h2f_vram_wraddr  <= head_c.addr;
        bus.h2f_vram_wrdata  <= head_c.data;
        bus.h2f_vram_byteena <= head_c.be;
      end
    end
  end

  // A read issued alongside a write is dropped entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.avs_readdatavalid <= 1'b0;
      bus.avs_readdata      <= '0;
    end else begin
      bus.avs_readdatavalid <= rd_c;
      bus.avs_readdata      <= (rd_c && is_csr_c) ? csr_word_c : '0;
    end
  end

  // Commit sequencing; the counter reaches ACK_TIMEOUT on the cycle the wait is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.cpu_vram_wr_irq <= 1'b0;
      ack_cnt             <= '0;
      ack_seen            <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      if (clr_to_c) timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_c) state <= DRAIN;
        end
        DRAIN: begin
          if (empty_c && !bus.h2f_vram_wren) begin
            state               <= NOTIFY;
            bus.cpu_vram_wr_irq <= 1'b1;
          end
        end
        NOTIFY: begin
          bus.cpu_vram_wr_irq <= 1'b0;
          state               <= WAIT_ACK;
          ack_cnt             <= '0;
          ack_seen            <= 1'b0;
        end
        WAIT_ACK: begin
          if (ack_seen) begin
            if (!bus.cpu_wr_busy) state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
            if (bus.cpu_wr_busy) begin
              ack_seen <= 1'b1;
            end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_h2f_vram_bridge.sv
// Directed bench for h2f_vram_bridge: buffering, back-pressure, commit fencing,
// PPU acknowledge, ack timeout and mid-drain reset.
module tb_h2f_vram_bridge;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  h2f_vram_bridge_if bus ();

  h2f_vram_bridge #(.FIFO_DEPTH(16), .ACK_TIMEOUT(1023)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds a write until accepted; returns at posedge+1 with the strobe dropped.
  task automatic avs_wr(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be);
    bit ok = 1'b0;
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    bus.avs_byteenable = be;
    bus.avs_write      = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.avs_waitrequest === 1'b0) ok = 1'b1;
      step();
    end
    bus.avs_write = 1'b0;
    chk("wr_accept", 64'(ok), 64'd1);
  endtask

  task automatic csr_read(output logic [63:0] rd);
    bus.avs_address = 14'h2000;
    bus.avs_read    = 1'b1;
    step();
    bus.avs_read = 1'b0;
    chk("csr_rdvalid", 64'(bus.avs_readdatavalid), 64'd1);
    rd = bus.avs_readdata;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wren"},    64'(bus.h2f_vram_wren),     64'd0);
    chk({tag, "_wraddr"},  64'(bus.h2f_vram_wraddr),   64'd0);
    chk({tag, "_wrdata"},  bus.h2f_vram_wrdata,        64'd0);
    chk({tag, "_byteena"}, 64'(bus.h2f_vram_byteena),  64'd0);
    chk({tag, "_irq"},     64'(bus.cpu_vram_wr_irq),   64'd0);
    chk({tag, "_rdvalid"}, 64'(bus.avs_readdatavalid), 64'd0);
    chk({tag, "_rddata"},  bus.avs_readdata,           64'd0);
    chk({tag, "_waitreq"}, 64'(bus.avs_waitrequest),   64'd0);
  endtask

  initial begin
    logic [63:0] rd;
    int          nwr;
    int          wr_cyc [17];
    bit          acc;
    int          acc_cyc;
    int          irq_cyc;
    int          irq_cnt;
    int          pend_cnt;
    bit          any_bad;

    rst_n              = 1'b0;
    bus.avs_address    = '0;
    bus.avs_write      = 1'b0;
    bus.avs_writedata  = '0;
    bus.avs_byteenable = '0;
    bus.avs_read       = 1'b0;
    bus.cpu_wr_busy    = 1'b0;
    #23;
    chk_outputs_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // 1: single write reaches the PPU two cycles after acceptance
    avs_wr(14'h0005, 64'h1122_3344_5566_7788, 8'hFF);
    chk("t1_wren_n1", 64'(bus.h2f_vram_wren), 64'd0);
    step();
    chk("t1_wren_n2",  64'(bus.h2f_vram_wren),    64'd1);
    chk("t1_wraddr",   64'(bus.h2f_vram_wraddr),  64'h5);
    chk("t1_wrdata",   bus.h2f_vram_wrdata,       64'h1122_3344_5566_7788);
    chk("t1_byteena",  64'(bus.h2f_vram_byteena), 64'hFF);
    step();
    chk("t1_wren_off", 64'(bus.h2f_vram_wren), 64'd0);
    csr_read(rd);
    chk("t1_csr", rd, 64'h1);

    // be=0 write alongside a read: write completes, nothing pushed, read dropped
    bus.avs_address    = 14'h0007;
    bus.avs_writedata  = 64'hDEAD_BEEF_0000_0001;
    bus.avs_byteenable = 8'h00;
    bus.avs_write      = 1'b1;
    bus.avs_read       = 1'b1;
    @(negedge clk);
    chk("be0_waitreq", 64'(bus.avs_waitrequest), 64'd0);
    step();
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    chk("rw_same_rdvalid", 64'(bus.avs_readdatavalid), 64'd0);
    any_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.h2f_vram_wren !== 1'b0) any_bad = 1'b1;
    end
    chk("be0_no_wren", 64'(any_bad), 64'd0);
    csr_read(rd);
    chk("be0_csr", rd, 64'h1);
    bus.avs_address = 14'h0005;
    bus.avs_read    = 1'b1;
    step();
    bus.avs_read = 1'b0;
    chk("vram_rd_valid", 64'(bus.avs_readdatavalid), 64'd1);
    chk("vram_rd_data",  bus.avs_readdata,           64'd0);
    step();
    chk("rdvalid_single", 64'(bus.avs_readdatavalid), 64'd0);

    // 2: fill while PPU busy, 17th write back-pressured, then ordered drain
    bus.cpu_wr_busy = 1'b1;
    for (int i = 0; i < 16; i++)
      avs_wr(14'(i), 64'hD000_0000_0000_0000 | 64'(i), 8'(i + 1));
    csr_read(rd);
    chk("t2_csr_full", rd, 64'h1000);
    bus.avs_address    = 14'd16;
    bus.avs_writedata  = 64'hD000_0000_0000_0010;
    bus.avs_byteenable = 8'h11;
    bus.avs_write      = 1'b1;
    @(negedge clk);
    chk("t2_waitreq_full", 64'(bus.avs_waitrequest), 64'd1);
    step();
    bus.cpu_wr_busy = 1'b0;
    nwr = 0;
    acc = 1'b0;
    for (int cyc = 0; cyc < 60 && nwr < 17; cyc++) begin
      bit acc_now;
      @(negedge clk);
      acc_now = bus.avs_write && (bus.avs_waitrequest === 1'b0);
      step();
      if (acc_now) begin
        bus.avs_write = 1'b0;
        acc = 1'b1;
      end
      if (bus.h2f_vram_wren === 1'b1) begin
        chk("t2_addr", 64'(bus.h2f_vram_wraddr),  64'(nwr));
        chk("t2_data", bus.h2f_vram_wrdata,       64'hD000_0000_0000_0000 | 64'(nwr));
        chk("t2_be",   64'(bus.h2f_vram_byteena), 64'(8'(nwr + 1)));
        wr_cyc[nwr] = cyc;
        nwr++;
      end
    end
    bus.avs_write = 1'b0;
    chk("t2_count",    64'(nwr), 64'd17);
    chk("t2_17th_acc", 64'(acc), 64'd1);
    chk("t2_burst",    64'(wr_cyc[15] - wr_cyc[0]), 64'd15);
    step();

    // 3+4: commit fences buffered writes; new write waits for IDLE; PPU acks with busy
    bus.cpu_wr_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      avs_wr(14'h0100 + 14'(i), 64'hC0DE_0000_0000_0000 + 64'(i), 8'hF0 | 8'(i + 1));
    avs_wr(14'h2000, 64'h1, 8'hFF);
    csr_read(rd);
    chk("t3_csr_drain", rd, 64'h0302);
    bus.avs_address    = 14'h1FFF;
    bus.avs_writedata  = 64'hFFEE_DDCC_BBAA_9988;
    bus.avs_byteenable = 8'h0F;
    bus.avs_write      = 1'b1;
    @(negedge clk);
    chk("t3_waitreq_drain", 64'(bus.avs_waitrequest), 64'd1);
    step();
    bus.cpu_wr_busy = 1'b0;
    nwr = 0; acc = 1'b0; acc_cyc = 0; irq_cyc = -100; irq_cnt = 0;
    for (int cyc = 0; cyc < 80 && nwr < 4; cyc++) begin
      bit acc_now;
      @(negedge clk);
      acc_now = bus.avs_write && (bus.avs_waitrequest === 1'b0);
      step();
      if (acc_now) begin
        bus.avs_write = 1'b0;
        acc = 1'b1;
        acc_cyc = cyc;
      end
      if (bus.cpu_vram_wr_irq === 1'b1) begin
        irq_cnt++;
        irq_cyc = cyc;
      end
      if (bus.h2f_vram_wren === 1'b1) begin
        if (nwr < 3) begin
          chk("t3_addr", 64'(bus.h2f_vram_wraddr),  64'h100 + 64'(nwr));
          chk("t3_data", bus.h2f_vram_wrdata,       64'hC0DE_0000_0000_0000 + 64'(nwr));
          chk("t3_be",   64'(bus.h2f_vram_byteena), 64'(8'hF0 | 8'(nwr + 1)));
        end else begin
          chk("t3_late_addr", 64'(bus.h2f_vram_wraddr),  64'h1FFF);
          chk("t3_late_data", bus.h2f_vram_wrdata,       64'hFFEE_DDCC_BBAA_9988);
          chk("t3_late_be",   64'(bus.h2f_vram_byteena), 64'h0F);
        end
        wr_cyc[nwr] = cyc;
        nwr++;
      end
      bus.cpu_wr_busy = (irq_cnt > 0) && (cyc - irq_cyc < 5);
    end
    bus.avs_write   = 1'b0;
    bus.cpu_wr_busy = 1'b0;
    chk("t3_wr_count",  64'(nwr), 64'd4);
    chk("t3_irq_count", 64'(irq_cnt), 64'd1);
    chk("t3_irq_after_fence", 64'(irq_cyc - wr_cyc[2]), 64'd2);
    chk("t3_late_acc_after_ack", 64'(acc && (acc_cyc > irq_cyc + 5)), 64'd1);
    step();
    csr_read(rd);
    chk("t4_csr_idle", rd, 64'h1);

    // 5: commit with no acknowledge times out after 1023 WAIT_ACK cycles
    avs_wr(14'h2000, 64'h1, 8'hFF);
    bus.avs_address = 14'h2000;
    bus.avs_read    = 1'b1;
    pend_cnt = 0; irq_cnt = 0; rd = '1;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      step();
      if (bus.cpu_vram_wr_irq === 1'b1) irq_cnt++;
      if (bus.avs_readdatavalid === 1'b1) begin
        rd = bus.avs_readdata;
        if (rd[1]) pend_cnt++;
        else break;
      end
    end
    bus.avs_read = 1'b0;
    chk("t5_irq_count",   64'(irq_cnt), 64'd1);
    chk("t5_pending_len", 64'(pend_cnt), 64'd1025);
    chk("t5_csr_timeout", rd, 64'h5);
    step();
    avs_wr(14'h2000, 64'h2, 8'hFF);
    csr_read(rd);
    chk("t5_csr_cleared", rd, 64'h1);

    // 6: reset while draining with 4 buffered entries
    bus.cpu_wr_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      avs_wr(14'h0040 + 14'(i), 64'hAB00_0000_0000_0000 + 64'(i), 8'hFF);
    avs_wr(14'h2000, 64'h1, 8'hFF);
    step();
    csr_read(rd);
    chk("t6_csr_before", rd, 64'h0402);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    bus.cpu_wr_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    any_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.h2f_vram_wren !== 1'b0 || bus.cpu_vram_wr_irq !== 1'b0) any_bad = 1'b1;
    end
    chk("t6_quiet_after_reset", 64'(any_bad), 64'd0);
    csr_read(rd);
    chk("t6_csr_after", rd, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
